// File: rtl/ps2_keyflags.sv
// PS/2 receiver with glitch filter, frame timeout, scan-code FIFO
// and make/break tracking of a small set of key codes.
//
// Ports:
//   clk, reset        system clock, sync active-high reset
//   ps2d, ps2c        asynchronous PS/2 data / clock lines
//   rx_en             receive enable, looked at only between frames
//   rd_en             pop the FIFO head
//   out_reg[10:0]     last frame: start, data LSB first, parity, stop
//   code[7:0]         FIFO head (valid while fifo_empty=0)
//   fifo_empty/full   FIFO status
//   overflow          sticky, good byte dropped on a full FIFO
//   frame_err         sticky, parity/start/stop/timeout error
//   key_flags         bit k set while key k is held
module ps2_keyflags #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int NKEYS       = 4,
  // key 0 = 1C, key 1 = 1B, key 2 = 23, key 3 = 2B
  parameter logic [8*NKEYS-1:0] KEY_CODES = 32'h2B231B1C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2d,
  input  logic             ps2c,
  input  logic             rx_en,
  input  logic             rd_en,
  output logic [10:0]      out_reg,
  output logic [7:0]       code,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow,
  output logic             frame_err,
  output logic [NKEYS-1:0] key_flags
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_filt;
  logic [FW-1:0] f_cnt;
  logic          fall;

  state_t        state;
  logic [10:0]   sr;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          brk;

  logic [7:0]    data;
  logic          good;
  logic          wr, rd;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // The filtered level flips after FILTER_LEN consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_filt <= 1'b1;
      f_cnt  <= '0;
    end else if (c_s2 == c_filt) begin
      f_cnt <= '0;
    end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
      c_filt <= c_s2;
      f_cnt  <= '0;
    end else begin
      f_cnt <= f_cnt + 1'b1;
    end
  end

  // Asserted in the cycle the filter accepts a 1->0 change.
  assign fall = c_filt & ~c_s2 &
                (f_cnt == FW'(FILTER_LEN - 1));

  // Bits enter at the MSB, so after 11 shifts sr[0] is the start bit.
  assign data = sr[8:1];
  assign good = ~sr[0] & sr[10] & (^sr[9:1]);
  assign wr   = (state == CHECK) & good & (data != 8'hF0);
  assign rd   = rd_en & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      out_reg   <= '0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      key_flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall && rx_en) begin
            sr      <= {d_s2, sr[10:1]};
            bit_cnt <= 4'd10;
            timer   <= '0;
            state   <= RX;
          end
        end
        RX: begin
          if (fall) begin
            sr      <= {d_s2, sr[10:1]};
            bit_cnt <= bit_cnt - 4'd1;
            timer   <= '0;
            if (bit_cnt == 4'd1)
              state <= CHECK;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          out_reg <= sr;
          state   <= IDLE;
          if (!good) begin
            frame_err <= 1'b1;
          end else if (data == 8'hF0) begin
            brk <= 1'b1;
          end else begin
            brk <= 1'b0;
            for (int k = 0; k < NKEYS; k++)
              if (data == KEY_CODES[8*k +: 8])
                key_flags[k] <= ~brk;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wp == rp);
  assign fifo_full  = ((wp - rp) == (AW + 1)'(FIFO_DEPTH));
  assign code       = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (rd)
        rp <= rp + 1'b1;
      if (wr) begin
        // A pop in the same cycle does not make room for a write.
        if (fifo_full)
          overflow <= 1'b1;
        else
          wp <= wp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr && !fifo_full)
      mem[wp[AW-1:0]] <= data;
  end

endmodule

// File: tb/tb_ps2_keyflags.sv
// Testbench for ps2_keyflags: directed and random PS/2 frames
// checked against a queue-based make/break reference model.
module tb_ps2_keyflags;

  localparam int FL = 8;
  localparam int FD = 8;
  localparam int TO = 300;
  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ps2d = 1'b1;
  logic          ps2c = 1'b1;
  logic          rx_en = 1'b1;
  logic          rd_en = 1'b0;
  logic [10:0]   out_reg;
  logic [7:0]    code;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
  logic          frame_err;
  logic [NK-1:0] key_flags;

  ps2_keyflags #(
    .FILTER_LEN (FL),
    .FIFO_DEPTH (FD),
    .TIMEOUT_CYC(TO),
    .NKEYS      (NK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2d      (ps2d),
    .ps2c      (ps2c),
    .rx_en     (rx_en),
    .rd_en     (rd_en),
    .out_reg   (out_reg),
    .code      (code),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .frame_err (frame_err),
    .key_flags (key_flags)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]    mq [$];
  logic [7:0]    kc [NK] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
  logic [NK-1:0] m_keys;
  bit            m_brk, m_ovf, m_ferr;
  logic [10:0]   m_out;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_model();
    mq.delete();
    m_keys = '0;
    m_brk  = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    m_out  = '0;
  endtask

  task automatic do_reset();
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rd_en = 1'b0;
    rx_en = 1'b1;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    clr_model();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"},   32'(out_reg),    32'(m_out));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
    chk({tag, "_full"},  32'(fifo_full),  32'(mq.size() == FD));
    chk({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    chk({tag, "_ferr"},  32'(frame_err),  32'(m_ferr));
    chk({tag, "_keys"},  32'(key_flags),  32'(m_keys));
    if (mq.size() > 0)
      chk({tag, "_code"}, 32'(code), 32'(mq[0]));
  endtask

  task automatic model_frame(input logic [10:0] f);
    logic [7:0] d;
    bit g;
    d = f[8:1];
    g = !f[0] && f[10] && (^f[9:1]);
    m_out = f;
    if (!g) begin
      m_ferr = 1'b1;
    end else if (d == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (mq.size() == FD) m_ovf = 1'b1;
      else mq.push_back(d);
      for (int k = 0; k < NK; k++)
        if (kc[k] == d) m_keys[k] = ~m_brk;
      m_brk = 1'b0;
    end
  endtask

  // Data is set up mid-high phase, then the clock falls.
  // A glitch pulls ps2c low for 3 cycles inside the high phase.
  task automatic send_bit(input bit b, input bit gl);
    ps2d = b;
    if (gl) begin
      cyc(6);
      ps2c = 1'b0;
      cyc(3);
      ps2c = 1'b1;
      cyc(11);
    end else begin
      cyc(20);
    end
    ps2c = 1'b0;
    cyc(20);
    ps2c = 1'b1;
  endtask

  // err: 0 none, 1 parity, 2 start, 3 stop
  task automatic send_frame(input logic [7:0] d, input int err,
                            input int gl_bit, input int drop_at);
    logic [10:0] f;
    bit cap;
    f[0]   = (err == 2);
    f[8:1] = d;
    f[9]   = ~(^d) ^ (err == 1);
    f[10]  = (err != 3);
    cap = rx_en;
    for (int i = 0; i < 11; i++) begin
      if (i == drop_at) rx_en = 1'b0;
      send_bit(f[i], i == gl_bit);
    end
    cyc(30);
    if (cap) model_frame(f);
  endtask

  task automatic pop(input string tag);
    bit ne;
    ne = (mq.size() > 0);
    if (ne) chk({tag, "_pop"}, 32'(code), 32'(mq[0]));
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (ne) void'(mq.pop_front());
    cyc(1);
  endtask

  initial begin
    int t, r, e;
    logic [7:0] d;

    // reset state
    do_reset();
    check_all("rst");
    chk("rst_out0", 32'(out_reg), 32'h0);

    // single good 1C
    send_frame(8'h1C, 0, -1, -1);
    chk("f1c_out", 32'(out_reg), 32'h438);
    chk("f1c_code", 32'(code), 32'h1C);
    chk("f1c_keys", 32'(key_flags), 32'h1);
    chk("f1c_ferr", 32'(frame_err), 32'h0);
    check_all("f1c");
    pop("f1c");
    check_all("f1c_after");

    // pop on an empty FIFO is ignored
    pop("empty_rd");
    check_all("empty_rd");

    // make, break prefix, make code again
    send_frame(8'h1C, 0, -1, -1);
    send_frame(8'hF0, 0, -1, -1);
    send_frame(8'h1C, 0, -1, -1);
    chk("brk_keys", 32'(key_flags), 32'h0);
    chk("brk_n", 32'(fifo_empty), 32'h0);
    check_all("brk");
    pop("brk0");
    pop("brk1");
    chk("brk_empty", 32'(fifo_empty), 32'h1);
    // break_pending cleared: 1C makes the key again
    send_frame(8'h1C, 0, -1, -1);
    chk("brk_clr", 32'(key_flags), 32'h1);
    check_all("brk_clr");

    // bad parity on 23
    send_frame(8'h23, 1, -1, -1);
    chk("par_ferr", 32'(frame_err), 32'h1);
    chk("par_out", 32'(out_reg), 32'h646);
    check_all("par");

    // timeout on a partial frame, then a good 2B
    do_reset();
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
    cyc(TO + 5);
    m_ferr = 1'b1;
    send_frame(8'h2B, 0, -1, -1);
    chk("to_ferr", 32'(frame_err), 32'h1);
    chk("to_key3", 32'(key_flags[3]), 32'h1);
    chk("to_code", 32'(code), 32'h2B);
    check_all("to");

    // glitch on ps2c during RX
    do_reset();
    send_frame(8'h1B, 0, 4, -1);
    chk("gl_code", 32'(code), 32'h1B);
    check_all("gl");

    // rx_en low for a whole frame ignores it; falling mid frame doesn't
    rx_en = 1'b0;
    send_frame(8'h23, 0, -1, -1);
    rx_en = 1'b1;
    check_all("rxoff");
    send_frame(8'h23, 0, -1, 3);
    rx_en = 1'b1;
    check_all("rxdrop");

    // overflow
    do_reset();
    for (int i = 0; i <= FD; i++) begin
      t = $urandom_range(0, 255);
      d = 8'(t);
      if (d == 8'hF0) d = 8'h11;
      send_frame(d, 0, -1, -1);
    end
    chk("ovf_full", 32'(fifo_full), 32'h1);
    chk("ovf_ovf", 32'(overflow), 32'h1);
    check_all("ovf");
    for (int i = 0; i < FD; i++) pop("ovf");
    chk("ovf_empty", 32'(fifo_empty), 32'h1);
    check_all("ovf_end");

    // random traffic
    do_reset();
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      t = $urandom_range(0, 255);
      if (r < 4) d = kc[r];
      else if (r < 6) d = 8'hF0;
      else d = 8'(t);
      e = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      rx_en = ($urandom_range(0, 9) != 0);
      send_frame(d, e, -1, -1);
      rx_en = 1'b1;
      check_all("rnd");
      if ($urandom_range(0, 2) == 0) pop("rnd");
    end
    while (mq.size() > 0) pop("drain");
    check_all("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
